alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a single-cycle-settle ALU: accepts one command, issues registered
// operands, captures the result and holds it until downstream accepts, counting completions.
module alu_cmd_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [3:0]       i_cmd_a,
   input  logic [3:0]       i_cmd_b,
   input  logic [2:0]       i_cmd_op,
   output logic [3:0]       o_alu_a,
   output logic [3:0]       o_alu_b,
   output logic [2:0]       o_alu_op,
   input  logic [5:0]       i_alu_out,
   input  logic             i_alu_ovf,
   input  logic             i_alu_z,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [5:0]       o_res_data,
   output logic             o_res_ovf,
   output logic             o_res_zero,
   output logic             o_busy,
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_cmd_count,
   output logic [CNT_W-1:0] o_ovf_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_capture;
   logic             w_done;
   logic [3:0]       r_alu_a;
   logic [3:0]       r_alu_b;
   logic [2:0]       r_alu_op;
   logic [5:0]       r_res_data;
   logic             r_res_ovf;
   logic             r_res_zero;
   logic [CNT_W-1:0] r_cmd_count;
   logic [CNT_W-1:0] r_ovf_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept = i_cmd_valid;
            if (i_cmd_valid) w_next = ISSUE;
         end
         ISSUE:   w_next = CAPTURE;
         CAPTURE: begin
            w_capture = 1'b1;
            w_next    = HOLD;
         end
         HOLD: begin
            w_done = i_res_ready;
            if (i_res_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Operands stay put after the transfer so the ALU sees them through ISSUE and CAPTURE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (w_accept) begin
         r_alu_a  <= i_cmd_a;
         r_alu_b  <= i_cmd_b;
         r_alu_op <= i_cmd_op;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_res_data <= '0;
         r_res_ovf  <= 1'b0;
         r_res_zero <= 1'b0;
      end else if (w_capture) begin
         r_res_data <= i_alu_out;
         r_res_ovf  <= i_alu_ovf;
         r_res_zero <= i_alu_z;
      end
   end

   // Clear wins over a same-edge completion; both counters stick at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cmd_count <= '0;
         r_ovf_count <= '0;
      end else if (i_cnt_clr) begin
         r_cmd_count <= '0;
         r_ovf_count <= '0;
      end else if (w_done) begin
         if (!(&r_cmd_count))             r_cmd_count <= r_cmd_count + 1'b1;
         if (r_res_ovf && !(&r_ovf_count)) r_ovf_count <= r_ovf_count + 1'b1;
      end
   end

   assign o_cmd_ready = (r_state == IDLE);
   assign o_busy      = (r_state != IDLE);
   assign o_res_valid = (r_state == HOLD);
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_op    = r_alu_op;
   assign o_res_data  = r_res_data;
   assign o_res_ovf   = r_res_ovf;
   assign o_res_zero  = r_res_zero;
   assign o_cmd_count = r_cmd_count;
   assign o_ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: stub ALU, vector table, scoreboard and hand-written corner sequences.
module tb_alu_cmd_sequencer;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [3:0] cmd_a = '0, cmd_b = '0;
   logic [2:0] cmd_op = '0;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [5:0] alu_out;
   logic alu_ovf, alu_z;
   logic res_valid, res_ready = 1'b0;
   logic [5:0] res_data;
   logic res_ovf, res_zero, busy;
   logic cnt_clr = 1'b0;
   logic [CNT_W-1:0] cmd_count, ovf_count;
   logic stub_force = 1'b0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] data;
      logic       ovf;
      logic       zero;
   } res_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [5:0] data;
      logic       ovf;
      logic       zero;
   } vec_t;

   // Stub ALU behaviour; forced mode returns out=0, ovf=1, z=1.
   function automatic res_t alu_model(input logic [3:0] a, input logic [3:0] b,
                                      input logic [2:0] op, input logic frc);
      res_t r;
      logic [5:0] o;
      case (op)
         3'd0:    o = {2'b0, a} + {2'b0, b};
         3'd1:    o = {2'b0, a} - {2'b0, b};
         3'd2:    o = {2'b0, a & b};
         3'd3:    o = {2'b0, a | b};
         3'd4:    o = {2'b0, a ^ b};
         3'd5:    o = {1'b0, a, 1'b0};
         3'd6:    o = {2'b0, ~a};
         default: o = 6'd0;
      endcase
      r.data = o;
      r.ovf  = (o > 6'd15);
      r.zero = (o == 6'd0);
      if (frc) r = {6'd0, 1'b1, 1'b1};
      return r;
   endfunction

   res_t w_stub;
   assign w_stub  = alu_model(alu_a, alu_b, alu_op, stub_force);
   assign alu_out = w_stub.data;
   assign alu_ovf = w_stub.ovf;
   assign alu_z   = w_stub.zero;

   alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_op(cmd_op),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
      .i_alu_out(alu_out), .i_alu_ovf(alu_ovf), .i_alu_z(alu_z),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_data(res_data), .o_res_ovf(res_ovf), .o_res_zero(res_zero),
      .o_busy(busy), .i_cnt_clr(cnt_clr),
      .o_cmd_count(cmd_count), .o_ovf_count(ovf_count)
   );

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard and counter model, all sampled on the falling edge.
   res_t sb[$];
   res_t cur_exp = '0;
   logic prev_valid = 1'b0;
   int   m_cmd = 0, m_ovf = 0;
   int   cyc = 0, acc_cnt = 0, last_acc = -1;
   logic burst = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_cmd = 0;
         m_ovf = 0;
         prev_valid = 1'b0;
      end else begin
         check("cmd_count_model", cmd_count, m_cmd);
         check("ovf_count_model", ovf_count, m_ovf);
         if (cmd_valid && cmd_ready) begin
            sb.push_back(alu_model(cmd_a, cmd_b, cmd_op, stub_force));
            acc_cnt++;
            if (burst && last_acc >= 0) check("accept_interval", cyc - last_acc, 4);
            last_acc = cyc;
         end
         if (res_valid && !prev_valid) begin
            check("sb_occupancy", sb.size(), 1);
            if (sb.size() > 0) begin
               cur_exp = sb.pop_front();
               check("sb_res_data", res_data, cur_exp.data);
               check("sb_res_ovf", res_ovf, cur_exp.ovf);
               check("sb_res_zero", res_zero, cur_exp.zero);
            end
         end else if (res_valid) begin
            check("hold_stable_data", res_data, cur_exp.data);
            check("hold_stable_flags", {res_ovf, res_zero}, {cur_exp.ovf, cur_exp.zero});
         end
         prev_valid = res_valid;
         if (cnt_clr) begin
            m_cmd = 0;
            m_ovf = 0;
         end else if (res_valid && res_ready) begin
            if (m_cmd < CMAX) m_cmd++;
            if (cur_exp.ovf && m_ovf < CMAX) m_ovf++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      check("send_ready", cmd_ready, 1);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!res_valid && k < 20) begin tick(); k++; end
      if (!res_valid) check("wait_valid_timeout", res_valid, 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!cmd_ready && k < 20) begin tick(); k++; end
      if (!cmd_ready) check("wait_idle_timeout", cmd_ready, 1);
   endtask

   vec_t vt[10];
   int   sv_cmd, sv_ovf;

   initial begin
      vt[0] = '{4'd9,  4'd5,  3'd0, 6'd14, 1'b0, 1'b0};
      vt[1] = '{4'd15, 4'd15, 3'd0, 6'd30, 1'b1, 1'b0};
      vt[2] = '{4'd3,  4'd5,  3'd1, 6'd62, 1'b1, 1'b0};
      vt[3] = '{4'd12, 4'd10, 3'd2, 6'd8,  1'b0, 1'b0};
      vt[4] = '{4'd12, 4'd3,  3'd2, 6'd0,  1'b0, 1'b1};
      vt[5] = '{4'd9,  4'd6,  3'd3, 6'd15, 1'b0, 1'b0};
      vt[6] = '{4'd10, 4'd10, 3'd4, 6'd0,  1'b0, 1'b1};
      vt[7] = '{4'd11, 4'd0,  3'd5, 6'd22, 1'b1, 1'b0};
      vt[8] = '{4'd5,  4'd0,  3'd6, 6'd10, 1'b0, 1'b0};
      vt[9] = '{4'd7,  4'd7,  3'd7, 6'd0,  1'b0, 1'b1};

      // Reset state
      #2;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_alu_regs", {alu_a, alu_b, alu_op}, 0);
      check("rst_res", {res_data, res_ovf, res_zero}, 0);
      check("rst_counts", {cmd_count, ovf_count}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Latency: accept at N, ISSUE, CAPTURE, result valid after N+2
      res_ready = 1'b1;
      send(4'd9, 4'd5, 3'd0);
      check("lat_n_busy", busy, 1);
      check("lat_n_ready", cmd_ready, 0);
      check("lat_n_valid", res_valid, 0);
      check("lat_n_alu_regs", {alu_a, alu_b, alu_op}, {4'd9, 4'd5, 3'd0});
      tick();
      check("lat_n1_valid", res_valid, 0);
      tick();
      check("lat_n2_valid", res_valid, 1);
      check("lat_n2_data", res_data, 14);
      check("lat_n2_flags", {res_ovf, res_zero}, 0);
      tick();
      check("lat_n3_valid", res_valid, 0);
      check("lat_cmd_count", cmd_count, 1);
      check("lat_ovf_count", ovf_count, 0);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         send(vt[i].a, vt[i].b, vt[i].op);
         wait_valid();
         check($sformatf("vec%0d_data", i), res_data, vt[i].data);
         check($sformatf("vec%0d_ovf", i), res_ovf, vt[i].ovf);
         check($sformatf("vec%0d_zero", i), res_zero, vt[i].zero);
         wait_idle();
      end

      // Held result with backpressure; a second command must be ignored
      stub_force = 1'b1;
      res_ready  = 1'b0;
      send(4'd3, 4'd4, 3'd2);
      wait_valid();
      sv_cmd = m_cmd;
      sv_ovf = m_ovf;
      cmd_valid = 1'b1; cmd_a = 4'd15; cmd_b = 4'd1; cmd_op = 3'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_cmd_ready", cmd_ready, 0);
         check("hold_res", {res_data, res_ovf, res_zero}, {6'd0, 1'b1, 1'b1});
         check("hold_alu_regs", {alu_a, alu_b, alu_op}, {4'd3, 4'd4, 3'd2});
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      check("hold_release_valid", res_valid, 0);
      check("hold_release_cmd", cmd_count, sv_cmd + 1);
      check("hold_release_ovf", ovf_count, sv_ovf + 1);
      stub_force = 1'b0;
      tick();

      // Back-to-back burst: 20 cycles of cmd_valid
      acc_cnt = 0; last_acc = -1; burst = 1'b1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         tick();
      end
      cmd_valid = 1'b0;
      burst = 1'b0;
      check("burst_accepts", acc_cnt, 5);
      wait_idle();

      // Saturation: 300 more completions
      cmd_valid = 1'b1;
      for (int i = 0; i < 1200; i++) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
         tick();
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("sat_cmd_count", cmd_count, CMAX);

      // Clear coincident with HOLD->IDLE
      send(4'd8, 4'd8, 3'd0);
      wait_valid();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_cmd_count", cmd_count, 0);
      check("clr_ovf_count", ovf_count, 0);
      check("clr_valid", res_valid, 0);

      // Asynchronous reset in CAPTURE
      send(4'd6, 4'd7, 3'd0);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", res_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", cmd_ready, 1);
      check("arst_alu_regs", {alu_a, alu_b, alu_op}, 0);
      check("arst_res", {res_data, res_ovf, res_zero}, 0);
      check("arst_counts", {cmd_count, ovf_count}, 0);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("arst_post_counts", {cmd_count, ovf_count}, 0);
      send(4'd2, 4'd3, 3'd0);
      wait_valid();
      check("arst_next_data", res_data, 5);
      wait_idle();
      check("arst_next_cmd_count", cmd_count, 1);
      check("arst_next_ovf_count", ovf_count, 0);
      tick();
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
